// File: rtl/decode_pkg.sv
// Shared definitions for the ARM decode stage:
// uop classes, condition codes, flag bit positions and the control bundle.
package decode_pkg;

    localparam logic [3:0] UOP_NONE      = 4'd0;
    localparam logic [3:0] UOP_BRANCH    = 4'd1;
    localparam logic [3:0] UOP_INTEGER   = 4'd2;
    localparam logic [3:0] UOP_INTEGER_M = 4'd3;
    localparam logic [3:0] UOP_LOAD      = 4'd4;
    localparam logic [3:0] UOP_STORE     = 4'd5;
    localparam logic [3:0] UOP_FP        = 4'd6;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [27:0] NOP_ENC = 28'h320F000;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [3:0] cls;
        logic [3:0] opcode;
        logic [2:0] mtype;
        logic [7:0] shift;
        logic       exec;
        logic       wr_do;
        logic       wr_m;
        logic       wr_cpsr;
    } dec_ctrl_t;

    // TST/TEQ/CMP/CMN only update flags
    function automatic logic is_test_op(input logic [3:0] opc);
        return opc[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/decode_stage_cond_check.sv
// Combinational ARM condition-code evaluator.
// Reports whether cond passes against the given NZCV flags.
module cond_check
    import decode_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = n == v;
            COND_LT: pass = n != v;
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered ARM decode stage: classify, check condition, bypass operands,
// and hand packets to execute through an output register plus skid entry.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 4,
    parameter int NUM_FWD = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                instr_i,
    input  logic                       flush,
    input  logic                       flags_we,
    input  logic [3:0]                 flags_i,
    output logic [4*REG_W-1:0]         rr_addr_o,
    input  logic [4*DATA_W-1:0]        rr_data_i,
    input  logic [NUM_FWD-1:0]         fwd_valid,
    input  logic [NUM_FWD*REG_W-1:0]   fwd_reg,
    input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [3:0]                 out_class,
    output logic [3:0]                 out_opcode,
    output logic [2:0]                 out_type,
    output logic [7:0]                 out_shift,
    output logic [DATA_W-1:0]          out_a,
    output logic [DATA_W-1:0]          out_b,
    output logic [DATA_W-1:0]          out_c,
    output logic [DATA_W-1:0]          out_d,
    output logic [REG_W-1:0]           out_dest,
    output logic                       out_exec,
    output logic                       out_wr_do,
    output logic                       out_wr_m,
    output logic                       out_wr_cpsr
);

    typedef struct packed {
        dec_ctrl_t         ctrl;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] c;
        logic [DATA_W-1:0] d;
    } pkt_t;

    logic [3:0]        flags_q;
    logic [3:0]        eff_flags;
    logic              cond_pass;
    logic [REG_W-1:0]  ra   [4];
    logic [DATA_W-1:0] opnd [4];
    logic              is_nop, is_mul, is_dp, is_sdt, is_br;
    logic              test_op;
    pkt_t              nxt, out_q, skid_q;
    logic              out_v, skid_v;
    logic              in_fire;

    function automatic logic [DATA_W-1:0] rot_imm(input logic [11:0] f);
        logic [DATA_W-1:0] x;
        logic [4:0]        r;
        x = DATA_W'(f[7:0]);
        r = {f[11:8], 1'b0};
        return (x >> r) | (x << (DATA_W - int'(r)));
    endfunction

    assign eff_flags = flags_we ? flags_i : flags_q;

    cond_check u_cond (
        .cond (instr_i[31:28]),
        .nzcv (eff_flags),
        .pass (cond_pass)
    );

    assign is_nop  = instr_i[27:0] == NOP_ENC;
    assign is_mul  = !is_nop && !instr_i[25] && instr_i[7] && instr_i[4];
    assign is_dp   = !is_nop && !is_mul && instr_i[27:26] == 2'b00;
    assign is_sdt  = !is_mul && instr_i[27:26] == 2'b01;
    assign is_br   = instr_i[27:25] == 3'b101;
    assign test_op = is_test_op(instr_i[24:21]);

    // Multiply reads Rm,Rs,Rd,Rn; everything else reads Rn,Rm,Rs,Rd
    always_comb begin
        if (is_mul) begin
            ra[0] = REG_W'(instr_i[3:0]);
            ra[1] = REG_W'(instr_i[11:8]);
            ra[2] = REG_W'(instr_i[19:16]);
            ra[3] = REG_W'(instr_i[15:12]);
        end else begin
            ra[0] = REG_W'(instr_i[19:16]);
            ra[1] = REG_W'(instr_i[3:0]);
            ra[2] = REG_W'(instr_i[11:8]);
            ra[3] = REG_W'(instr_i[15:12]);
        end
    end

    assign rr_addr_o = {ra[3], ra[2], ra[1], ra[0]};

    // Scan oldest to youngest so the lowest-index match wins
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            opnd[k] = rr_data_i[k*DATA_W +: DATA_W];
            for (int i = NUM_FWD - 1; i >= 0; i--) begin
                if (fwd_valid[i] && fwd_reg[i*REG_W +: REG_W] == ra[k])
                    opnd[k] = fwd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        nxt           = '0;
        nxt.ctrl.exec = cond_pass;
        unique case (1'b1)
            is_nop: nxt.ctrl.exec = 1'b0;
            is_mul: begin
                nxt.ctrl.cls   = UOP_INTEGER_M;
                nxt.ctrl.mtype = instr_i[23:21];
                nxt.ctrl.wr_m  = !instr_i[23];
                nxt.dest       = REG_W'(instr_i[19:16]);
                nxt.a          = opnd[0];
                nxt.b          = opnd[1];
                nxt.c          = opnd[2];
                nxt.d          = opnd[3];
            end
            is_dp: begin
                nxt.ctrl.cls     = UOP_INTEGER;
                nxt.ctrl.opcode  = instr_i[24:21];
                nxt.ctrl.wr_do   = !test_op;
                nxt.ctrl.wr_cpsr = instr_i[20] || test_op;
                nxt.dest         = REG_W'(instr_i[15:12]);
                nxt.a            = opnd[0];
                if (instr_i[25]) begin
                    nxt.b = rot_imm(instr_i[11:0]);
                end else begin
                    nxt.b          = opnd[1];
                    nxt.ctrl.shift = instr_i[11:4];
                end
            end
            is_sdt: begin
                nxt.ctrl.cls   = instr_i[20] ? UOP_LOAD : UOP_STORE;
                nxt.ctrl.wr_do = instr_i[20];
                nxt.dest       = REG_W'(instr_i[15:12]);
                nxt.a          = opnd[0];
                nxt.b          = DATA_W'(instr_i[11:0]);
                nxt.d          = opnd[3];
            end
            is_br: begin
                nxt.ctrl.cls = UOP_BRANCH;
                nxt.b = {{(DATA_W-26){instr_i[23]}}, instr_i[23:0], 2'b00};
            end
            default: ;
        endcase
    end

    assign in_fire = in_valid && !skid_v && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            out_v   <= 1'b0;
            skid_v  <= 1'b0;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            if (flags_we)
                flags_q <= flags_i;
            if (flush) begin
                out_v  <= 1'b0;
                skid_v <= 1'b0;
            end else if (skid_v) begin
                if (out_ready) begin
                    out_q  <= skid_q;
                    skid_v <= 1'b0;
                end
            end else if (in_fire) begin
                if (!out_v || out_ready) begin
                    out_q <= nxt;
                    out_v <= 1'b1;
                end else begin
                    skid_q <= nxt;
                    skid_v <= 1'b1;
                end
            end else if (out_ready) begin
                out_v <= 1'b0;
            end
        end
    end

    assign in_ready    = !skid_v;
    assign out_valid   = out_v;
    assign out_class   = out_q.ctrl.cls;
    assign out_opcode  = out_q.ctrl.opcode;
    assign out_type    = out_q.ctrl.mtype;
    assign out_shift   = out_q.ctrl.shift;
    assign out_exec    = out_q.ctrl.exec;
    assign out_wr_do   = out_q.ctrl.wr_do;
    assign out_wr_m    = out_q.ctrl.wr_m;
    assign out_wr_cpsr = out_q.ctrl.wr_cpsr;
    assign out_dest    = out_q.dest;
    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_c       = out_q.c;
    assign out_d       = out_q.d;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a
// randomized run against an instruction-level reference model.
module tb_decode_stage;

    localparam int NF = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid, in_ready, flush, flags_we;
    logic [31:0] instr;
    logic [3:0] flags_in;
    logic [15:0] rr_addr;
    logic [127:0] rr_data;
    logic [1:0] fwd_valid;
    logic [7:0] fwd_reg;
    logic [63:0] fwd_data;
    logic out_valid, out_ready, out_exec, out_wr_do, out_wr_m, out_wr_cpsr;
    logic [3:0] out_class, out_opcode, out_dest;
    logic [2:0] out_type;
    logic [7:0] out_shift;
    logic [31:0] out_a, out_b, out_c, out_d;

    logic [31:0] regs [16];
    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] cls, opc;
        logic [2:0] typ;
        logic [7:0] sh;
        logic [3:0] dest;
        logic exec, wdo, wm, wc;
        logic [31:0] a, b, c, d;
    } exp_t;

    exp_t expq[$];
    logic [3:0] flags_m;

    always #5 clk = ~clk;

    assign rr_data = {regs[rr_addr[15:12]], regs[rr_addr[11:8]],
                      regs[rr_addr[7:4]], regs[rr_addr[3:0]]};

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .instr_i(instr), .flush(flush), .flags_we(flags_we), .flags_i(flags_in),
        .rr_addr_o(rr_addr), .rr_data_i(rr_data), .fwd_valid(fwd_valid),
        .fwd_reg(fwd_reg), .fwd_data(fwd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_class(out_class), .out_opcode(out_opcode),
        .out_type(out_type), .out_shift(out_shift), .out_a(out_a), .out_b(out_b),
        .out_c(out_c), .out_d(out_d), .out_dest(out_dest), .out_exec(out_exec),
        .out_wr_do(out_wr_do), .out_wr_m(out_wr_m), .out_wr_cpsr(out_wr_cpsr)
    );

    function automatic logic [31:0] src(input logic [3:0] r);
        for (int i = 0; i < NF; i++)
            if (fwd_valid[i] && fwd_reg[i*4 +: 4] == r) return fwd_data[i*32 +: 32];
        return regs[r];
    endfunction

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && n == v;
            4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t predict(input logic [31:0] ins, input logic [3:0] f);
        exp_t e;
        int r, off;
        logic [31:0] x;
        logic tst;
        e = '0;
        e.exec = cond_ok(ins[31:28], f);
        tst = ins[24:21] >= 4'd8 && ins[24:21] <= 4'd11;
        if (ins[27:0] == 28'h320F000) begin
            e.exec = 1'b0;
        end else if (!ins[25] && ins[7] && ins[4]) begin
            e.cls = 4'd3; e.typ = ins[23:21]; e.wm = !ins[23];
            e.dest = ins[19:16];
            e.a = src(ins[3:0]); e.b = src(ins[11:8]);
            e.c = src(ins[19:16]); e.d = src(ins[15:12]);
        end else if (ins[27:26] == 2'b00) begin
            e.cls = 4'd2; e.opc = ins[24:21]; e.dest = ins[15:12];
            e.wdo = !tst; e.wc = ins[20] || tst;
            e.a = src(ins[19:16]);
            if (ins[25]) begin
                x = {24'd0, ins[7:0]};
                r = 2 * int'(ins[11:8]);
                e.b = (r == 0) ? x : ((x >> r) | (x << (32 - r)));
            end else begin
                e.b = src(ins[3:0]); e.sh = ins[11:4];
            end
        end else if (ins[27:26] == 2'b01) begin
            e.cls = ins[20] ? 4'd4 : 4'd5; e.wdo = ins[20];
            e.dest = ins[15:12]; e.a = src(ins[19:16]);
            e.b = {20'd0, ins[11:0]}; e.d = src(ins[15:12]);
        end else if (ins[27:25] == 3'b101) begin
            e.cls = 4'd1;
            off = int'(ins[23:0]);
            if (ins[23]) off = off - 32'h0100_0000;
            e.b = 32'(off * 4);
        end
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.cls = out_class; o.opc = out_opcode; o.typ = out_type; o.sh = out_shift;
        o.dest = out_dest; o.exec = out_exec; o.wdo = out_wr_do; o.wm = out_wr_m;
        o.wc = out_wr_cpsr; o.a = out_a; o.b = out_b; o.c = out_c; o.d = out_d;
        return o;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 6))
            0: w[27:25] = 3'b001;
            1: begin w[27:25] = 3'b000; w[4] = 1'b0; end
            2: begin w[27:22] = 6'd0; w[7:4] = 4'b1001; end
            3: w[27:26] = 2'b01;
            4: w[27:25] = 3'b101;
            5: w[27:0] = 28'h320F000;
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_class !== 4'd0 || out_a !== 32'd0 || out_exec !== 1'b0) begin errors++; $display("FAIL rst_pkt got cls=%h a=%h exec=%b exp=0", out_class, out_a, out_exec); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_dp_imm();
        out_ready = 1'b1; regs[2] = 32'd5;
        in_valid = 1'b1; instr = 32'hE28214FF; #1;
        checks++; if (rr_addr[3:0] !== 4'd2) begin errors++; $display("FAIL dp_raddr got=%h exp=2", rr_addr[3:0]); end
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dp_valid got=%b exp=1", out_valid); end
        checks++; if (out_b !== 32'hFF000000) begin errors++; $display("FAIL dp_b got=%h exp=ff000000", out_b); end
        checks++; if (out_a !== 32'd5) begin errors++; $display("FAIL dp_a got=%h exp=5", out_a); end
        checks++; if (out_dest !== 4'd1 || out_class !== 4'd2 || out_opcode !== 4'd4) begin errors++; $display("FAIL dp_dec got dest=%h cls=%h opc=%h exp 1 2 4", out_dest, out_class, out_opcode); end
        checks++; if (out_exec !== 1'b1 || out_wr_do !== 1'b1 || out_wr_cpsr !== 1'b0) begin errors++; $display("FAIL dp_ctl got exec=%b wdo=%b wc=%b exp 1 1 0", out_exec, out_wr_do, out_wr_cpsr); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_mul();
        regs[3] = 32'h33; regs[4] = 32'h44; regs[5] = 32'h55; regs[0] = 32'h10;
        in_valid = 1'b1; instr = 32'hE0030594; #1;
        checks++; if (rr_addr[7:0] !== 8'h54) begin errors++; $display("FAIL mul_raddr got=%h exp=54", rr_addr[7:0]); end
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_class !== 4'd3 || out_wr_m !== 1'b1 || out_wr_do !== 1'b0) begin errors++; $display("FAIL mul_dec got cls=%h wm=%b wdo=%b exp 3 1 0", out_class, out_wr_m, out_wr_do); end
        checks++; if (out_a !== 32'h44 || out_b !== 32'h55 || out_c !== 32'h33 || out_d !== 32'h10 || out_dest !== 4'd3) begin errors++; $display("FAIL mul_ops got a=%h b=%h c=%h d=%h dest=%h exp 44 55 33 10 3", out_a, out_b, out_c, out_d, out_dest); end
        @(negedge clk);
    endtask

    task automatic test_fwd();
        fwd_valid = 2'b11; fwd_reg = {4'd2, 4'd2}; fwd_data = {32'hBBBB, 32'hAAAA};
        in_valid = 1'b1; instr = 32'hE0420002;
        @(negedge clk);
        checks++; if (out_a !== 32'hAAAA || out_b !== 32'hAAAA) begin errors++; $display("FAIL fwd_prio got a=%h b=%h exp aaaa aaaa", out_a, out_b); end
        fwd_valid = 2'b10;
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_a !== 32'hBBBB || out_b !== 32'hBBBB) begin errors++; $display("FAIL fwd_p1 got a=%h b=%h exp bbbb bbbb", out_a, out_b); end
        fwd_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_cond();
        flags_we = 1'b1; flags_in = 4'b0100;
        in_valid = 1'b1; instr = 32'h03A00001;
        @(negedge clk); flags_we = 1'b0; instr = 32'h13A00001;
        checks++; if (out_exec !== 1'b1) begin errors++; $display("FAIL cond_eq_bypass got=%b exp=1", out_exec); end
        @(negedge clk); instr = 32'hE320F000;
        checks++; if (out_exec !== 1'b0) begin errors++; $display("FAIL cond_ne got=%b exp=0", out_exec); end
        @(negedge clk); instr = 32'h93A00001;
        checks++; if (out_class !== 4'd0 || out_exec !== 1'b0 || out_wr_do !== 1'b0) begin errors++; $display("FAIL nop got cls=%h exec=%b wdo=%b exp 0 0 0", out_class, out_exec, out_wr_do); end
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_exec !== 1'b1) begin errors++; $display("FAIL cond_ls got=%b exp=1", out_exec); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hE3A00011;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
        instr = 32'hE3A00022;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2 got=%b exp=0", in_ready); end
        instr = 32'hE3A00033;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0 || out_b !== 32'h11 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got rdy=%b b=%h v=%b exp 0 11 1", in_ready, out_b, out_valid); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_b !== 32'h22 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_second got b=%h rdy=%b exp 22 1", out_b, in_ready); end
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_b !== 32'h33 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got b=%h v=%b exp 33 1", out_b, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hE3A00044;
        @(negedge clk); instr = 32'hE3A00055;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fl_full got v=%b rdy=%b exp 1 0", out_valid, in_ready); end
        flush = 1'b1; instr = 32'hE3A00066;
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL fl_clear got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_stay got=%b exp=0", out_valid); end
        in_valid = 1'b1; flush = 1'b1; instr = 32'hE3A00077;
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_drop got=%b exp=0", out_valid); end
        in_valid = 1'b1; instr = 32'h03A00001;
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_exec !== 1'b1) begin errors++; $display("FAIL fl_flags got exec=%b exp=1", out_exec); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'hE3A00088;
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_pre got=%b exp=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ar_async got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; instr = 32'h03A00001;
        @(negedge clk); in_valid = 1'b0;
        checks++; if (out_exec !== 1'b0) begin errors++; $display("FAIL ar_flags got exec=%b exp=0", out_exec); end
        @(negedge clk);
    endtask

    task automatic test_random();
        exp_t got;
        logic acc;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        expq.delete();
        flags_m = 4'd0;
        for (int cyc = 0; cyc < 606; cyc++) begin
            checks++; if (out_valid !== (expq.size() != 0)) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out_valid, expq.size() != 0); end
            checks++; if (in_ready !== (expq.size() < 2)) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, in_ready, expq.size() < 2); end
            if (out_valid && expq.size() != 0) begin
                got = observed();
                checks++; if (got !== expq[0]) begin errors++; $display("FAIL rand_pkt cyc=%0d got=%h exp=%h", cyc, got, expq[0]); end
            end
            if (cyc < 600) begin
                flush = $urandom_range(0, 39) == 0;
                in_valid = $urandom_range(0, 3) != 0;
                out_ready = flush ? 1'b0 : ($urandom_range(0, 2) != 0);
                instr = gen_instr();
                fwd_valid = 2'($urandom);
                fwd_reg[3:0] = $urandom_range(0, 1) ? instr[19:16] : 4'($urandom);
                fwd_reg[7:4] = $urandom_range(0, 1) ? instr[3:0] : 4'($urandom);
                fwd_data = {$urandom, $urandom};
                flags_we = $urandom_range(0, 5) == 0;
                flags_in = 4'($urandom);
            end else begin
                flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flags_we = 1'b0;
            end
            acc = in_valid && expq.size() < 2;
            if (flush) expq.delete();
            else begin
                if (out_valid && out_ready && expq.size() != 0) void'(expq.pop_front());
                if (acc) expq.push_back(predict(instr, flags_we ? flags_in : flags_m));
            end
            if (flags_we) flags_m = flags_in;
            @(negedge clk);
        end
    endtask

    initial begin
        in_valid = 1'b0; instr = 32'd0; flush = 1'b0; flags_we = 1'b0; flags_in = 4'd0;
        fwd_valid = 2'b00; fwd_reg = 8'd0; fwd_data = 64'd0; out_ready = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 32'h100 + i;
        @(negedge clk);
        test_reset();
        test_dp_imm();
        test_mul();
        test_fwd();
        test_cond();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised ARM decode stage sitting between fetch and execute.
- Classifies each instruction into a uop class, evaluates its condition against an internal NZCV flag register, and drives register-file read addresses.
- Resolves operands through NUM_FWD bypass ports and expands rotated immediates.
- Presents a packet to execute over a valid/ready handshake, with a 2-entry skid buffer so fetch sees a fully registered in_ready.

Parameters:
- DATA_W, 32, datapath width (operands, forwarded data, register-file data).
- REG_W, 4, register index width.
- NUM_FWD, 2, number of bypass ports; index 0 is youngest and has highest priority.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage can accept; equals !skid_full
- instr_i  in  32  instruction word
- flush  in  1  discard all held and incoming packets
- flags_we  in  1  execute writes flags this cycle
- flags_i  in  4  new NZCV (bit3=N, bit2=Z, bit1=C, bit0=V)
- rr_addr_o  out  4*REG_W  register-file read addresses for ports 1..4, combinational from instr_i
- rr_data_i  in  4*DATA_W  register-file read data, same cycle as rr_addr_o
- fwd_valid  in  NUM_FWD  bypass entry valid
- fwd_reg  in  NUM_FWD*REG_W  bypass destination register
- fwd_data  in  NUM_FWD*DATA_W  bypass data
- out_valid  out  1  packet valid to execute
- out_ready  in  1  execute accepts
- out_class  out  4  uop class
- out_opcode  out  4  DP opcode
- out_type  out  3  multiply type, instr[23:21]
- out_shift  out  8  instr[11:4] for register operand2; 0 for immediate form
- out_a, out_b, out_c, out_d  out  DATA_W each  operands
- out_dest  out  REG_W  destination register
- out_exec  out  1  condition passed
- out_wr_do, out_wr_m, out_wr_cpsr  out  1 each  write enables

Behaviour:
- Reset: all outputs 0, flags 0000, skid buffer empty, in_ready=1 once rst_n deasserts.
- Latency: an instruction accepted at edge N appears on out_* after edge N, if the output register is free.
- Handshake:
  - A transfer occurs when valid && ready.
  - out_* hold stable while out_valid && !out_ready.
  - If the output register is stalled, the accepted packet goes to the skid entry.
  - in_ready falls the cycle after the skid entry fills.
  - The skid entry drains into the output register on the first out_ready.
  - Order is always preserved.
- Decode priority:
  - NOP: instr[27:0]=0x320F000. Class 0; all write enables 0; out_exec forced 0.
  - Multiply: instr[25]=0 && instr[7]=1 && instr[4]=1. UOP_INTEGER_M. Reads Rm[3:0], Rs[11:8], Rd[19:16], Rn[15:12] into a, b, c, d. dest=instr[19:16]; wr_m=!instr[23]; wr_do=0; wr_cpsr=0.
  - Data processing: instr[27:26]=00. UOP_INTEGER. a=Rn[19:16]; dest=instr[15:12].
    - If instr[25]=1: b = imm8 zero-extended to DATA_W, rotated right by 2*instr[11:8].
    - Otherwise: b = Rm[3:0].
    - wr_do=1 except for TST/TEQ/CMP/CMN (opcodes 8-B), where wr_do=0.
    - wr_cpsr = instr[20] || opcode in 8-B.
  - Single data transfer: instr[27:26]=01. UOP_LOAD if instr[20]=1, else UOP_STORE. a=Rn; b=zero-extended offset[11:0]; d=Rd; dest=Rd; wr_do = load.
  - Branch: instr[27:25]=101. UOP_BRANCH. b = sign-extended offset<<2.
  - Anything else: class 0; all write enables 0.
- Operand resolution, per register operand:
  - Take the lowest-index fwd port with fwd_valid && fwd_reg == source index.
  - If no port matches, use rr_data_i.
  - Immediates are never forwarded.
- Condition evaluation:
  - Evaluated against eff_flags = flags_we ? flags_i : flags_q, i.e. same-cycle flag bypass.
  - EQ=Z, NE=!Z, CS=C, CC=!C, MI=N, PL=!N, VS=V, VC=!V.
  - HI = C && !Z; LS = !C || Z.
  - GE = N==V; LT = N!=V.
  - GT = !Z && N==V; LE = Z || N!=V.
  - AL=1; 1111=0.
  - out_exec is registered along with the packet.
- Flags: flags_q <= flags_i on flags_we, independent of handshake and stalls.
- Flush:
  - At the next edge, out_valid=0 and skid is empty; flags are preserved.
  - An instruction presented in the flush cycle is dropped.
  - flush takes priority over a simultaneous in_valid or out_ready.
- Mid-operation reset clears packets and flags immediately (asynchronous).

Decomposition:
- decode_pkg holds:
  - UOP_BRANCH=1, UOP_INTEGER=2, UOP_INTEGER_M=3, UOP_LOAD=4, UOP_STORE=5, UOP_FP=6.
  - Condition code constants, the AL and NOP encodings, and the NZCV bit positions.
  - A packed decode-packet struct shared by the output register and the skid entry.
- Sub-module cond_check (combinational): cond[3:0] and nzcv[3:0] in, pass out.

Test Plan:
- Reset, then ADD r1,r2,#0xFF rotated 8 (0xE28214FF) with r2=5 -> next cycle out_b=0xFF000000, out_a=5, out_dest=1, out_exec=1, wr_do=1.
- MUL r3,r4,r5 (0xE0030594) -> out_class=3, wr_m=1, rr_addr port1=4, port2=5.
- fwd_valid=2'b11, both fwd_reg=2, fwd_data={0xBBBB,0xAAAA}, SUB r0,r2,r2 -> out_a=out_b=0xAAAA (port 0 wins).
- flags_we=1 with Z=1 in the same cycle as MOVEQ (0x03A00001) -> out_exec=1; next instruction MOVNE -> out_exec=0.
- Hold out_ready=0 and push 3 instructions -> in_ready drops after the 2nd is accepted. Release -> packets emerge in order, none lost or duplicated.
- Two packets held, then flush=1 with in_valid=1 -> out_valid=0 next cycle and the incoming packet never appears; flags are unchanged.
